// File: rtl/radix3_pkg.sv
// Shared constants and FSM state type for the radix-3 butterfly stage.
package radix3_pkg;

   // sqrt(3)/2 in Q1.15, used for the imaginary rotation of bins 1 and 2.
   localparam int K         = 28378;
   localparam int COEF_W    = 16;
   localparam int COEF_FRAC = 15;

   // Output sequencer: IDLE, or which bin is currently on do_*.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OUT0 = 2'd1,
      OUT1 = 2'd2,
      OUT2 = 2'd3
   } state_t;

endpackage

// File: rtl/radix3_bf_stage_if.sv
// Sample-in / bin-out bus of the radix-3 butterfly stage.
//
// Handshake: di_en qualifies di_re/di_im for exactly one sample on each
// rising clk edge where it is high; there is no back-pressure, the stage
// always accepts. do_en qualifies do_re/do_im/do_idx/do_last for one bin on
// each rising clk edge where it is high; the consumer must take it.
interface radix3_bf_stage_if #(
   parameter int WIDTH     = 18,
   parameter int OUT_WIDTH = WIDTH + 2
);
   logic signed [WIDTH-1:0]     di_re;
   logic signed [WIDTH-1:0]     di_im;
   logic                        di_en;
   logic signed [OUT_WIDTH-1:0] do_re;
   logic signed [OUT_WIDTH-1:0] do_im;
   logic                        do_en;
   logic [1:0]                  do_idx;
   logic                        do_last;

   // Source of samples / sink of bins.
   modport master (
      output di_re, di_im, di_en,
      input  do_re, do_im, do_en, do_idx, do_last
   );

   // The butterfly stage itself.
   modport slave (
      input  di_re, di_im, di_en,
      output do_re, do_im, do_en, do_idx, do_last
   );
endinterface

// File: rtl/radix3_core.sv
// Combinational 3-point DFT: (a, b, c) -> (X0, X1, X2).
// Internals run at OUT_WIDTH+1 bits; results are truncated to OUT_WIDTH,
// which cannot overflow for full-scale WIDTH-bit inputs.
module radix3_core
   import radix3_pkg::*;
#(
   parameter int WIDTH     = 18,
   parameter int OUT_WIDTH = WIDTH + 2
) (
   input  logic signed [WIDTH-1:0]     a_re,
   input  logic signed [WIDTH-1:0]     a_im,
   input  logic signed [WIDTH-1:0]     b_re,
   input  logic signed [WIDTH-1:0]     b_im,
   input  logic signed [WIDTH-1:0]     c_re,
   input  logic signed [WIDTH-1:0]     c_im,
   output logic signed [OUT_WIDTH-1:0] x0_re,
   output logic signed [OUT_WIDTH-1:0] x0_im,
   output logic signed [OUT_WIDTH-1:0] x1_re,
   output logic signed [OUT_WIDTH-1:0] x1_im,
   output logic signed [OUT_WIDTH-1:0] x2_re,
   output logic signed [OUT_WIDTH-1:0] x2_im
);

   localparam int IW = OUT_WIDTH + 1;
   localparam int PW = IW + COEF_W;
   localparam logic signed [PW-1:0] K_EXT = PW'(K);
   localparam logic signed [PW-1:0] RND   = PW'(1) <<< (COEF_FRAC - 1);

   logic signed [IW-1:0] ae_re, ae_im, be_re, be_im, ce_re, ce_im;
   logic signed [IW-1:0] s_re, s_im, d_re, d_im, h_re, h_im;
   logic signed [IW-1:0] p_re, p_im, t_re, t_im;
   logic signed [IW-1:0] y0_re, y0_im, y1_re, y1_im, y2_re, y2_im;
   logic signed [PW-1:0] dx_re, dx_im, m_re, m_im;
   logic                 unused_bits;

   // Sign extension into the internal width.
   assign ae_re = {{(IW-WIDTH){a_re[WIDTH-1]}}, a_re};
   assign ae_im = {{(IW-WIDTH){a_im[WIDTH-1]}}, a_im};
   assign be_re = {{(IW-WIDTH){b_re[WIDTH-1]}}, b_re};
   assign be_im = {{(IW-WIDTH){b_im[WIDTH-1]}}, b_im};
   assign ce_re = {{(IW-WIDTH){c_re[WIDTH-1]}}, c_re};
   assign ce_im = {{(IW-WIDTH){c_im[WIDTH-1]}}, c_im};

   // Sum/difference of b and c; h is floor(s/2).
   assign s_re = be_re + ce_re;
   assign s_im = be_im + ce_im;
   assign d_re = be_re - ce_re;
   assign d_im = be_im - ce_im;
   assign h_re = s_re >>> 1;
   assign h_im = s_im >>> 1;

   // p = round_half_up(K * d / 2^15), kept fully signed through the shift.
   assign dx_re = {{(PW-IW){d_re[IW-1]}}, d_re};
   assign dx_im = {{(PW-IW){d_im[IW-1]}}, d_im};
   assign m_re  = (dx_re * K_EXT + RND) >>> COEF_FRAC;
   assign m_im  = (dx_im * K_EXT + RND) >>> COEF_FRAC;
   assign p_re  = m_re[IW-1:0];
   assign p_im  = m_im[IW-1:0];

   // Bins: X0 = a+s, X1/X2 = (a-h) -/+ j*p.
   assign t_re  = ae_re - h_re;
   assign t_im  = ae_im - h_im;
   assign y0_re = ae_re + s_re;
   assign y0_im = ae_im + s_im;
   assign y1_re = t_re + p_im;
   assign y1_im = t_im - p_re;
   assign y2_re = t_re - p_im;
   assign y2_im = t_im + p_re;

   assign x0_re = y0_re[OUT_WIDTH-1:0];
   assign x0_im = y0_im[OUT_WIDTH-1:0];
   assign x1_re = y1_re[OUT_WIDTH-1:0];
   assign x1_im = y1_im[OUT_WIDTH-1:0];
   assign x2_re = y2_re[OUT_WIDTH-1:0];
   assign x2_im = y2_im[OUT_WIDTH-1:0];

   // Guard bits dropped by truncation are intentionally discarded.
   assign unused_bits = ^{y0_re[IW-1], y0_im[IW-1], y1_re[IW-1], y1_im[IW-1],
                          y2_re[IW-1], y2_im[IW-1],
                          m_re[PW-1:IW], m_im[PW-1:IW]};

endmodule

// File: rtl/radix3_bf_stage.sv
// Serial radix-3 butterfly stage: groups the input stream into (a, b, c)
// triples and emits the three DFT bins one per cycle.
module radix3_bf_stage
   import radix3_pkg::*;
#(
   parameter int WIDTH     = 18,
   parameter int OUT_WIDTH = WIDTH + 2,
   parameter int FRAME_LEN = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   radix3_bf_stage_if.slave       bus,
   output state_t                 dbg_state
);

   localparam int FRM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   logic [1:0]                  in_cnt;
   logic [FRM_W-1:0]            frm_cnt;
   logic signed [WIDTH-1:0]     a_re, a_im, b_re, b_im;
   logic signed [OUT_WIDTH-1:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im;
   logic signed [OUT_WIDTH-1:0] r1_re, r1_im, r2_re, r2_im;
   logic                        r_last;
   logic                        grp_done;
   logic                        frm_end;
   state_t                      state;

   // c is arriving this cycle; the butterfly uses it straight off the bus.
   assign grp_done  = bus.di_en && (in_cnt == 2'd2);
   assign frm_end   = (frm_cnt == FRM_W'(FRAME_LEN - 1));
   assign dbg_state = state;

   radix3_core #(
      .WIDTH     (WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_core (
      .a_re  (a_re),
      .a_im  (a_im),
      .b_re  (b_re),
      .b_im  (b_im),
      .c_re  (bus.di_re),
      .c_im  (bus.di_im),
      .x0_re (x0_re),
      .x0_im (x0_im),
      .x1_re (x1_re),
      .x1_im (x1_im),
      .x2_re (x2_re),
      .x2_im (x2_im)
   );

   // Input side: store a and b, advance group and frame counters on each sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_cnt  <= '0;
         frm_cnt <= '0;
         a_re    <= '0;
         a_im    <= '0;
         b_re    <= '0;
         b_im    <= '0;
      end else if (bus.di_en) begin
         case (in_cnt)
            2'd0: begin
               a_re <= bus.di_re;
               a_im <= bus.di_im;
            end
            2'd1: begin
               b_re <= bus.di_re;
               b_im <= bus.di_im;
            end
            default: ;
         endcase
         in_cnt  <= grp_done ? 2'd0 : in_cnt + 2'd1;
         frm_cnt <= frm_end ? '0 : frm_cnt + FRM_W'(1);
      end
   end

   // Result buffer: X1, X2 and the end-of-frame flag captured at group completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_re  <= '0;
         r1_im  <= '0;
         r2_re  <= '0;
         r2_im  <= '0;
         r_last <= 1'b0;
      end else if (grp_done) begin
         r1_re  <= x1_re;
         r1_im  <= x1_im;
         r2_re  <= x2_re;
         r2_im  <= x2_im;
         r_last <= frm_end;
      end
   end

   // Output sequencer: state names the bin currently presented on do_*.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bus.do_re   <= '0;
         bus.do_im   <= '0;
         bus.do_en   <= 1'b0;
         bus.do_idx  <= 2'd0;
         bus.do_last <= 1'b0;
      end else begin
         case (state)
            OUT0: begin
               state       <= OUT1;
               bus.do_re   <= r1_re;
               bus.do_im   <= r1_im;
               bus.do_en   <= 1'b1;
               bus.do_idx  <= 2'd1;
               bus.do_last <= 1'b0;
            end
            OUT1: begin
               state       <= OUT2;
               bus.do_re   <= r2_re;
               bus.do_im   <= r2_im;
               bus.do_en   <= 1'b1;
               bus.do_idx  <= 2'd2;
               bus.do_last <= r_last;
            end
            default: begin
               // IDLE and OUT2: start the next group back-to-back if one just completed.
               if (grp_done) begin
                  state       <= OUT0;
                  bus.do_re   <= x0_re;
                  bus.do_im   <= x0_im;
                  bus.do_en   <= 1'b1;
                  bus.do_idx  <= 2'd0;
                  bus.do_last <= 1'b0;
               end else begin
                  state       <= IDLE;
                  bus.do_re   <= '0;
                  bus.do_im   <= '0;
                  bus.do_en   <= 1'b0;
                  bus.do_idx  <= 2'd0;
                  bus.do_last <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
